// File: rtl/neuron_mac.sv
// Neuron compute stage: streams activations against a 1-cycle-latency weight memory,
// accumulates the signed dot product, adds bias, rescales with saturation and activates.
module neuron_mac #(
  parameter int numWeight    = 30,
  parameter int addressWidth = $clog2(numWeight),
  parameter int dataWidth    = 16,
  parameter int fracBits     = 12,
  parameter int biasValue    = 0,
  parameter int actType      = 0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        x_valid,
  output logic                        x_ready,
  input  logic signed [dataWidth-1:0] x_in,
  output logic                        w_ren,
  output logic [addressWidth-1:0]     w_radd,
  input  logic signed [dataWidth-1:0] w_in,
  output logic                        out_valid,
  output logic signed [dataWidth-1:0] out_data
);

  localparam int AccW  = 2 * dataWidth + $clog2(numWeight);
  localparam int SumW  = AccW + 1;
  localparam int ProdW = 2 * dataWidth;

  localparam logic signed [dataWidth-1:0] BIAS_D = dataWidth'(biasValue);
  localparam logic signed [SumW-1:0] BIAS_SH =
    {{(SumW - dataWidth){BIAS_D[dataWidth-1]}}, BIAS_D} <<< fracBits;
  localparam logic signed [SumW-1:0] MAX_V =
    {{(SumW - dataWidth + 1){1'b0}}, {(dataWidth - 1){1'b1}}};
  localparam logic signed [SumW-1:0] MIN_V =
    {{(SumW - dataWidth + 1){1'b1}}, {(dataWidth - 1){1'b0}}};
  localparam logic [addressWidth-1:0] LAST_ADDR = addressWidth'(numWeight - 1);

  typedef enum logic [1:0] {ACC, DRAIN, FINAL} state_t;

  state_t                      state_reg;
  logic [addressWidth-1:0]     cnt_reg;
  logic signed [AccW-1:0]      acc_reg;
  logic signed [dataWidth-1:0] x_d_reg;
  logic                        v_d_reg;
  logic                        out_valid_reg;
  logic signed [dataWidth-1:0] out_data_reg;

  logic                        transfer;
  logic signed [ProdW-1:0]     x_ext;
  logic signed [ProdW-1:0]     w_ext;
  logic signed [ProdW-1:0]     prod;
  logic signed [AccW-1:0]      prod_ext;
  logic signed [SumW-1:0]      sum_next;
  logic signed [SumW-1:0]      shifted_next;
  logic signed [dataWidth-1:0] result_next;

  assign x_ready   = (state_reg == ACC);
  assign transfer  = x_valid & x_ready;
  assign w_ren     = transfer;
  assign w_radd    = cnt_reg;
  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;

  // x_d_reg lines up with w_in: both belong to the address issued one cycle earlier.
  assign x_ext    = {{dataWidth{x_d_reg[dataWidth-1]}}, x_d_reg};
  assign w_ext    = {{dataWidth{w_in[dataWidth-1]}}, w_in};
  assign prod     = x_ext * w_ext;
  assign prod_ext = {{(AccW - ProdW){prod[ProdW-1]}}, prod};

  always_comb begin
    sum_next     = {acc_reg[AccW-1], acc_reg} + BIAS_SH;
    shifted_next = sum_next >>> fracBits;
    result_next  = shifted_next[dataWidth-1:0];
    if (shifted_next > MAX_V) begin
      result_next = MAX_V[dataWidth-1:0];
    end else if (shifted_next < MIN_V) begin
      result_next = MIN_V[dataWidth-1:0];
    end
    if (actType == 0 && result_next[dataWidth-1]) begin
      result_next = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ACC;
      cnt_reg       <= '0;
      acc_reg       <= '0;
      x_d_reg       <= '0;
      v_d_reg       <= 1'b0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
    end else begin
      out_valid_reg <= 1'b0;
      case (state_reg)
        ACC: begin
          if (transfer) begin
            x_d_reg <= x_in;
            v_d_reg <= 1'b1;
            if (cnt_reg == LAST_ADDR) begin
              cnt_reg   <= '0;
              state_reg <= DRAIN;
            end else begin
              cnt_reg <= cnt_reg + addressWidth'(1);
            end
          end else begin
            v_d_reg <= 1'b0;
          end
        end
        DRAIN: begin
          v_d_reg   <= 1'b0;
          state_reg <= FINAL;
        end
        FINAL: begin
          v_d_reg       <= 1'b0;
          out_data_reg  <= result_next;
          out_valid_reg <= 1'b1;
          state_reg     <= ACC;
        end
        default: begin
          v_d_reg   <= 1'b0;
          state_reg <= ACC;
        end
      endcase

      // The final product lands during DRAIN, so the sum is complete by FINAL.
      if (state_reg == FINAL) begin
        acc_reg <= '0;
      end else if (v_d_reg) begin
        acc_reg <= acc_reg + prod_ext;
      end
    end
  end

endmodule

// File: tb/tb_neuron_mac.sv
// Directed and random checks of neuron_mac across three bias/activation variants
// sharing one activation stream, each with its own 1-cycle-latency weight memory.
module tb_neuron_mac;

  localparam int NW = 4;
  localparam int NI = 3;

  typedef struct {
    logic signed [15:0] data;
    int                 cyc;
  } exp_t;

  logic clk;
  logic rst_n;
  logic x_valid;
  logic signed [15:0] x_in;

  logic               x_ready_a   [NI];
  logic               w_ren_a     [NI];
  logic [1:0]         w_radd_a    [NI];
  logic signed [15:0] w_rd_a      [NI];
  logic               out_valid_a [NI];
  logic signed [15:0] out_data_a  [NI];

  logic signed [15:0] wmem [NW];
  logic signed [15:0] fx [NW];
  logic signed [15:0] fw [NW];
  logic signed [15:0] last_out [NI];
  exp_t exp_q [NI][$];

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;
  int addr_exp = 0;

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    neuron_mac #(
      .numWeight(NW),
      .dataWidth(16),
      .fracBits(12),
      .biasValue(gi == 2 ? 2048 : 0),
      .actType(gi == 1 ? 1 : 0)
    ) u_dut (
      .clk(clk),
      .rst_n(rst_n),
      .x_valid(x_valid),
      .x_ready(x_ready_a[gi]),
      .x_in(x_in),
      .w_ren(w_ren_a[gi]),
      .w_radd(w_radd_a[gi]),
      .w_in(w_rd_a[gi]),
      .out_valid(out_valid_a[gi]),
      .out_data(out_data_a[gi])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    for (int k = 0; k < NI; k++) begin
      if (w_ren_a[k]) w_rd_a[k] <= wmem[w_radd_a[k]];
    end
  end

  function automatic int act_of(input int k);
    return (k == 1) ? 1 : 0;
  endfunction

  function automatic int bias_of(input int k);
    return (k == 2) ? 2048 : 0;
  endfunction

  // Reference: exact dot product, floor shift, saturate, optional ReLU.
  function automatic logic signed [15:0] golden(input int act, input int bias);
    longint s = 0;
    longint r;
    for (int i = 0; i < NW; i++) s += longint'(fx[i]) * longint'(fw[i]);
    s += longint'(bias) * 4096;
    r = s >>> 12;
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
    if (act == 0 && r < 0) r = 0;
    return 16'(r);
  endfunction

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] expv);
    total_cnt++;
    assert (obs === expv) pass_cnt++;
    else $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, expv, cyc);
  endtask

  // Advance one clock, sample #1 after the edge and retire any produced result.
  task automatic cycle();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    for (int k = 0; k < NI; k++) begin
      if (out_valid_a[k] === 1'b1) begin
        if (exp_q[k].size() == 0) begin
          chk($sformatf("spurious_out_valid_i%0d", k), 1, 0);
        end else begin
          e = exp_q[k].pop_front();
          chk($sformatf("out_data_i%0d", k), out_data_a[k], e.data);
          chk($sformatf("latency_i%0d", k), cyc, e.cyc);
          $display("result inst%0d: out_data=%0d expected=%0d cycle=%0d",
                   k, out_data_a[k], e.data, cyc);
          last_out[k] = e.data;
        end
      end else begin
        chk($sformatf("out_hold_i%0d", k), out_data_a[k], last_out[k]);
      end
    end
  endtask

  task automatic accept(input logic signed [15:0] v, input bit last);
    int guard = 0;
    x_valid = 1'b1;
    x_in = v;
    #1;
    while (x_ready_a[0] !== 1'b1 && guard < 8) begin
      cycle();
      guard++;
    end
    chk("x_ready_wait", x_ready_a[0], 1);
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("w_ren_i%0d", k), w_ren_a[k], 1);
      chk($sformatf("w_radd_i%0d", k), w_radd_a[k], addr_exp);
    end
    if (last) begin
      for (int k = 0; k < NI; k++) begin
        exp_q[k].push_back('{data: golden(act_of(k), bias_of(k)), cyc: cyc + 3});
      end
    end
    cycle();
    x_valid = 1'b0;
    addr_exp = (addr_exp == NW - 1) ? 0 : addr_exp + 1;
  endtask

  // Offer a junk activation while the block drains; it must be refused.
  task automatic drain_check();
    x_valid = 1'b1;
    x_in = 16'sh7fff;
    repeat (2) begin
      #1;
      for (int k = 0; k < NI; k++) begin
        chk($sformatf("drain_x_ready_i%0d", k), x_ready_a[k], 0);
        chk($sformatf("drain_w_ren_i%0d", k), w_ren_a[k], 0);
      end
      cycle();
    end
    x_valid = 1'b0;
    #1;
    chk("x_ready_after_drain", x_ready_a[0], 1);
  endtask

  task automatic run_frame(input int max_gap);
    for (int i = 0; i < NW; i++) wmem[i] = fw[i];
    for (int i = 0; i < NW; i++) begin
      if (max_gap > 0) repeat ($urandom_range(0, max_gap)) cycle();
      accept(fx[i], i == NW - 1);
    end
    drain_check();
  endtask

  task automatic set_frame(input logic signed [15:0] xv, input logic signed [15:0] wv);
    for (int i = 0; i < NW; i++) begin
      fx[i] = xv;
      fw[i] = wv;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    x_valid = 1'b0;
    x_in = '0;
    for (int i = 0; i < NW; i++) wmem[i] = '0;
    for (int k = 0; k < NI; k++) last_out[k] = '0;
    repeat (3) cycle();
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("rst_w_ren_i%0d", k), w_ren_a[k], 0);
      chk($sformatf("rst_w_radd_i%0d", k), w_radd_a[k], 0);
    end
    rst_n = 1'b1;
    #1;
    chk("rst_x_ready", x_ready_a[0], 1);

    // T1: 1.0 x 1.0 four times
    set_frame(16'sd4096, 16'sd4096);
    run_frame(0);
    // T2: negative sum -> ReLU clamps, identity passes
    set_frame(16'sd4096, -16'sd4096);
    run_frame(0);
    // T3: positive and negative saturation
    set_frame(16'sd28672, 16'sd28672);
    run_frame(0);
    set_frame(-16'sd28672, 16'sd28672);
    run_frame(0);
    // T4: zero weights, bias alone
    for (int i = 0; i < NW; i++) begin
      fx[i] = 16'($urandom);
      fw[i] = '0;
    end
    run_frame(0);

    // T5: random data and random gaps
    for (int f = 0; f < 50; f++) begin
      for (int i = 0; i < NW; i++) begin
        if (f % 2 == 0) begin
          fx[i] = 16'($urandom);
          fw[i] = 16'($urandom);
        end else begin
          fx[i] = 16'($urandom_range(0, 16383)) - 16'sd8192;
          fw[i] = 16'($urandom_range(0, 16383)) - 16'sd8192;
        end
      end
      run_frame(2);
    end

    // T6: reset mid-frame discards the partial sum
    set_frame(16'sd4096, 16'sd4096);
    for (int i = 0; i < NW; i++) wmem[i] = fw[i];
    accept(fx[0], 1'b0);
    accept(fx[1], 1'b0);
    rst_n = 1'b0;
    addr_exp = 0;
    for (int k = 0; k < NI; k++) last_out[k] = '0;
    #1;
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("midrst_out_valid_i%0d", k), out_valid_a[k], 0);
      chk($sformatf("midrst_out_data_i%0d", k), out_data_a[k], 0);
      chk($sformatf("midrst_w_radd_i%0d", k), w_radd_a[k], 0);
    end
    cycle();
    rst_n = 1'b1;
    run_frame(0);

    repeat (5) cycle();
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("pending_results_i%0d", k), exp_q[k].size(), 0);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
